// File: rtl/dino_pkg.sv
// Game-state encodings shared by the dino game-flow controller and the score stage.
package dino_pkg;

   localparam logic [1:0] GS_IDLE = 2'd0;
   localparam logic [1:0] GS_RUN  = 2'd1;
   localparam logic [1:0] GS_OVER = 2'd2;

   // State register values double as the gs output encoding.
   typedef enum logic [1:0] {
      ST_IDLE = GS_IDLE,
      ST_RUN  = GS_RUN,
      ST_OVER = GS_OVER
   } gs_t;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: two-flop synchroniser, stability counter and
// rising-edge strobe of the debounced level.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_db;
   logic             r_db_prev;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_db      <= 1'b0;
         r_db_prev <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= raw;
         r_sync2   <= r_sync1;
         r_db_prev <= r_db;
         // Any sample agreeing with the current level restarts the count.
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign level = r_db;
   assign press = r_db & ~r_db_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Dino game-flow FSM: idle / run (with pause) / game-over with restart lockout.
module game_state_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int RESTART_LOCKOUT = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_jump,
   input  logic       btn_pause,
   input  logic       collision,
   output logic [1:0] gs,
   output logic       halt,
   output logic       jump_pulse,
   output logic       start_pulse
);

   import dino_pkg::*;

   localparam int LOCK_W = $clog2(RESTART_LOCKOUT + 1);
   localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(RESTART_LOCKOUT);

   logic              w_jump_press;
   logic              w_pause_press;
   logic              w_jump_level_unused;
   logic              w_pause_level_unused;

   gs_t               r_state;
   logic              r_paused;
   logic [LOCK_W-1:0] r_lock;
   logic              r_jump_pulse;
   logic              r_start_pulse;

   gs_t               w_next_state;
   logic              w_next_paused;
   logic [LOCK_W-1:0] w_next_lock;
   logic              w_jump_pulse;
   logic              w_start_pulse;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_jump),
      .level (w_jump_level_unused),
      .press (w_jump_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_pause),
      .level (w_pause_level_unused),
      .press (w_pause_press)
   );

   always_comb begin
      w_next_state  = r_state;
      w_next_paused = r_paused;
      w_jump_pulse  = 1'b0;
      w_start_pulse = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_paused = 1'b0;
            if (w_jump_press) begin
               w_next_state  = ST_RUN;
               w_start_pulse = 1'b1;
            end
         end
         ST_RUN: begin
            if (!r_paused) begin
               if (collision) begin
                  w_next_state  = ST_OVER;
                  w_next_paused = 1'b0;
               end else if (w_pause_press) begin
                  w_next_paused = 1'b1;
               end else if (w_jump_press) begin
                  w_jump_pulse = 1'b1;
               end
            end else if (w_pause_press) begin
               w_next_paused = 1'b0;
            end
         end
         ST_OVER: begin
            w_next_paused = 1'b0;
            if (w_jump_press && (r_lock == '0)) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state  = ST_IDLE;
            w_next_paused = 1'b0;
         end
      endcase
   end

   // Lockout loads on the edge entering OVER, then counts down and parks at 0.
   always_comb begin
      w_next_lock = r_lock;
      if ((r_state != ST_OVER) && (w_next_state == ST_OVER)) begin
         w_next_lock = LOCK_INIT;
      end else if (r_lock != '0) begin
         w_next_lock = r_lock - LOCK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_paused      <= 1'b0;
         r_lock        <= '0;
         r_jump_pulse  <= 1'b0;
         r_start_pulse <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_paused      <= w_next_paused;
         r_lock        <= w_next_lock;
         r_jump_pulse  <= w_jump_pulse;
         r_start_pulse <= w_start_pulse;
      end
   end

   assign gs          = r_state;
   assign halt        = r_paused;
   assign jump_pulse  = r_jump_pulse;
   assign start_pulse = r_start_pulse;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl with DEBOUNCE_CYCLES=4, RESTART_LOCKOUT=10.
module tb_game_state_ctrl;

   typedef struct {
      int         cyc;
      logic [1:0] gs;
      logic       halt;
      logic       jp;
      logic       sp;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       btn_jump;
   logic       btn_pause;
   logic       collision;
   logic [1:0] gs;
   logic       halt;
   logic       jump_pulse;
   logic       start_pulse;

   int         cyc;
   int         n_total;
   int         n_pass;
   bit         mon_en;
   exp_t       q[$];

   game_state_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .RESTART_LOCKOUT (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_jump    (btn_jump),
      .btn_pause   (btn_pause),
      .collision   (collision),
      .gs          (gs),
      .halt        (halt),
      .jump_pulse  (jump_pulse),
      .start_pulse (start_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: an output event is a gs/halt change or any pulse high; each
   // event must line up with the next expected entry at exactly its cycle.
   logic [1:0] prev_gs;
   logic       prev_halt;
   exp_t       m_e;
   bit         m_ev;

   always @(negedge clk) begin
      if (mon_en) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            m_e = q.pop_front();
            n_total++;
            $display("FAIL missed_event: required gs=%0d halt=%0d jp=%0d sp=%0d at cycle %0d, actual at cycle %0d gs=%0d halt=%0d jp=%0d sp=%0d",
                     m_e.gs, m_e.halt, m_e.jp, m_e.sp, m_e.cyc, cyc, gs, halt, jump_pulse, start_pulse);
         end
         m_ev = (gs !== prev_gs) || (halt !== prev_halt) || (jump_pulse !== 1'b0) || (start_pulse !== 1'b0);
         if (q.size() > 0 && q[0].cyc == cyc) begin
            m_e = q.pop_front();
            n_total++;
            if (gs === m_e.gs && halt === m_e.halt && jump_pulse === m_e.jp && start_pulse === m_e.sp)
               n_pass++;
            else
               $display("FAIL cycle_%0d: actual gs=%0d halt=%0d jp=%0d sp=%0d, required gs=%0d halt=%0d jp=%0d sp=%0d",
                        cyc, gs, halt, jump_pulse, start_pulse, m_e.gs, m_e.halt, m_e.jp, m_e.sp);
         end else if (m_ev) begin
            n_total++;
            $display("FAIL unexpected_event at cycle %0d: actual gs=%0d halt=%0d jp=%0d sp=%0d, required gs=%0d halt=%0d jp=0 sp=0",
                     cyc, gs, halt, jump_pulse, start_pulse, prev_gs, prev_halt);
         end
         prev_gs   = gs;
         prev_halt = halt;
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input logic [1:0] g, input logic h, input logic jp, input logic sp);
      exp_t x;
      x.cyc  = c;
      x.gs   = g;
      x.halt = h;
      x.jp   = jp;
      x.sp   = sp;
      q.push_back(x);
   endtask

   // A button driven just after edge d yields its state effect at edge d+7.
   initial begin
      n_total   = 0;
      n_pass    = 0;
      mon_en    = 1'b0;
      prev_gs   = 2'd0;
      prev_halt = 1'b0;
      reset     = 1'b1;
      btn_jump  = 1'b0;
      btn_pause = 1'b0;
      collision = 1'b0;

      goto(3);
      reset = 1'b0;
      push(3, 2'd0, 1'b0, 1'b0, 1'b0);
      mon_en = 1'b1;

      // Three-cycle glitch never debounces.
      goto(5);   btn_jump = 1'b1;
      goto(8);   btn_jump = 1'b0;
      push(30, 2'd0, 1'b0, 1'b0, 1'b0);

      // Start, then an in-game jump.
      goto(32);  btn_jump = 1'b1; push(39, 2'd1, 1'b0, 1'b0, 1'b1);
      goto(45);  btn_jump = 1'b0;
      goto(56);  btn_jump = 1'b1; push(63, 2'd1, 1'b0, 1'b1, 1'b0);
      goto(60);  btn_jump = 1'b0;

      // Pause; jump and collision ignored while paused; unpause.
      goto(75);  btn_pause = 1'b1; push(82, 2'd1, 1'b1, 1'b0, 1'b0);
      goto(79);  btn_pause = 1'b0;
      goto(90);  btn_jump = 1'b1; collision = 1'b1;
      goto(94);  btn_jump = 1'b0;
      goto(102); collision = 1'b0; push(104, 2'd1, 1'b1, 1'b0, 1'b0);
      goto(106); btn_pause = 1'b1; push(113, 2'd1, 1'b0, 1'b0, 1'b0);
      goto(110); btn_pause = 1'b0;

      // Collision coincident with a jump press, lockout, restart.
      goto(125); btn_jump = 1'b1;
      goto(129); btn_jump = 1'b0;
      goto(131); collision = 1'b1; push(132, 2'd2, 1'b0, 1'b0, 1'b0);
      goto(132); collision = 1'b0;
      goto(133); btn_jump = 1'b1;
      goto(137); btn_jump = 1'b0;
      goto(145); btn_jump = 1'b1; push(152, 2'd0, 1'b0, 1'b0, 1'b0);
      goto(149); btn_jump = 1'b0;
      goto(159); btn_jump = 1'b1; push(166, 2'd1, 1'b0, 1'b0, 1'b1);
      goto(163); btn_jump = 1'b0;

      // Reset from RUN.
      goto(175); reset = 1'b1; push(176, 2'd0, 1'b0, 1'b0, 1'b0);
      goto(177); reset = 1'b0;

      // Chatter every 2 cycles, then a steady hold.
      for (int i = 0; i < 10; i++) begin
         goto(180 + 2 * i);
         btn_jump = ((i % 2) == 0);
      end
      goto(200); btn_jump = 1'b1; push(207, 2'd1, 1'b0, 1'b0, 1'b1);

      // Reset while paused, with jump held through reset.
      goto(215); btn_pause = 1'b1; push(222, 2'd1, 1'b1, 1'b0, 1'b0);
      goto(219); btn_pause = 1'b0;
      goto(230); reset = 1'b1; push(231, 2'd0, 1'b0, 1'b0, 1'b0);
      goto(231); reset = 1'b0; push(238, 2'd1, 1'b0, 1'b0, 1'b1);
      goto(245); btn_jump = 1'b0;
      goto(265);

      while (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         n_total++;
         $display("FAIL unreached_event: required gs=%0d halt=%0d jp=%0d sp=%0d at cycle %0d, actual never checked",
                  x.gs, x.halt, x.jp, x.sp, x.cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
